// File: rtl/fft_bank_reader.sv
// fft_bank_reader
// Read side of the ping-pong sample-bank handshake. Waits for the writer to
// mark a bank full, drains it (bit-reversed or linear address order) into a
// valid/ready stream tagged with the natural index k, then hands the bank
// back to the writer with a one-cycle free_pulse. Banks are consumed strictly
// in the order 0,1,0,1,...
//
// Stream handshake: a beat transfers in every cycle where out_valid and
// out_ready are both high. Once out_valid is raised, it stays high, and
// out_data/out_index/out_last stay unchanged, until that beat transfers.
// out_valid never depends combinationally on out_ready.

module fft_bank_reader #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32,
    parameter int BITREV = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              full_pulse,
    input  logic              wr_bank,
    output logic              rd_en,
    output logic              rd_bank,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              free_pulse,
    output logic              free_bank,
    output logic              busy,
    output logic              ovf
);

    localparam logic [ADDR_W-1:0] K_LAST = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t              state;
    state_t              state_nx;

    logic [1:0]          full_flag;
    logic                next_bank;
    logic                ovf_r;
    logic [ADDR_W-1:0]   k_cnt;

    // Read issued last cycle; its data is on rd_data this cycle.
    logic                rd_pend;
    logic [ADDR_W-1:0]   pend_k;
    logic                pend_last;

    // Two-entry output FIFO of {data, k, last}.
    logic [DATA_W-1:0]   fifo_data [2];
    logic [ADDR_W-1:0]   fifo_k    [2];
    logic                fifo_last [2];
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          fifo_cnt;

    logic                fifo_empty;
    logic                fifo_push;
    logic                fifo_pop;
    logic                beat_acc;
    logic                room;

    logic                rd_en_c;
    logic                free_c;
    logic [1:0]          set_vec;
    logic [1:0]          clr_vec;

    logic [DATA_W-1:0]   head_data;
    logic [ADDR_W-1:0]   head_k;
    logic                head_last;

    // Mirror the address bits so the counter k walks the bank in FFT input order.
    function automatic logic [ADDR_W-1:0] bit_reverse(input logic [ADDR_W-1:0] v);
        logic [ADDR_W-1:0] r;
        r = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            r[i] = v[ADDR_W-1-i];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Output stage: FIFO head has priority, otherwise the in-flight RAM word
    // is presented directly so the first beat appears the cycle after rd_en.
    // ------------------------------------------------------------------

    // Select the beat at the head of the stream.
    always_comb begin
        head_data = '0;
        head_k    = '0;
        head_last = 1'b0;
        if (!fifo_empty) begin
            head_data = fifo_data[rd_ptr];
            head_k    = fifo_k[rd_ptr];
            head_last = fifo_last[rd_ptr];
        end else if (rd_pend) begin
            head_data = rd_data;
            head_k    = pend_k;
            head_last = pend_last;
        end
    end

    // Stream handshake and FIFO push/pop decisions.
    always_comb begin
        fifo_empty = (fifo_cnt == 2'd0);
        out_valid  = !fifo_empty || rd_pend;
        beat_acc   = out_valid && out_ready;
        fifo_pop   = beat_acc && !fifo_empty;
        // The in-flight word is stored unless it went straight out this cycle.
        fifo_push  = rd_pend && !(fifo_empty && beat_acc);
        // Never more than two beats between the RAM and the stream.
        room       = (fifo_cnt + {1'b0, rd_pend}) < 2'd2;
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, read strobe and bank-release pulse.
    always_comb begin
        state_nx = state;
        rd_en_c  = 1'b0;
        free_c   = 1'b0;
        case (state)
            S_IDLE: begin
                if (full_flag[next_bank]) begin
                    state_nx = S_READ;
                end
            end
            S_READ: begin
                if (room) begin
                    rd_en_c = 1'b1;
                    if (k_cnt == K_LAST) begin
                        state_nx = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (beat_acc && head_last) begin
                    free_c = 1'b1;
                    // Go straight to the other bank if it is already waiting.
                    state_nx = full_flag[~next_bank] ? S_READ : S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bank bookkeeping
    // ------------------------------------------------------------------

    // Decode which flags are set or cleared this cycle.
    always_comb begin
        set_vec = 2'b00;
        clr_vec = 2'b00;
        if (full_pulse) begin
            set_vec[wr_bank] = 1'b1;
        end
        if (free_c) begin
            clr_vec[next_bank] = 1'b1;
        end
    end

    // Full flags and sticky overflow; a set wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_flag <= 2'b00;
            ovf_r     <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (set_vec[b]) begin
                    full_flag[b] <= 1'b1;
                    if (full_flag[b] && !clr_vec[b]) begin
                        ovf_r <= 1'b1;
                    end
                end else if (clr_vec[b]) begin
                    full_flag[b] <= 1'b0;
                end
            end
        end
    end

    // Bank pointer alternates each time a bank is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_bank <= 1'b0;
        end else if (free_c) begin
            next_bank <= ~next_bank;
        end
    end

    // Sample counter k, advanced by each issued read; wraps to 0 after N-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_cnt <= '0;
        end else if (rd_en_c) begin
            k_cnt <= k_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline and FIFO
    // ------------------------------------------------------------------

    // Track the read in flight and the tag that travels with its data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend   <= 1'b0;
            pend_k    <= '0;
            pend_last <= 1'b0;
        end else begin
            rd_pend <= rd_en_c;
            if (rd_en_c) begin
                pend_k    <= k_cnt;
                pend_last <= (k_cnt == K_LAST);
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (fifo_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FIFO storage; contents are only observed through a valid occupancy.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_data[wr_ptr] <= rd_data;
            fifo_k[wr_ptr]    <= pend_k;
            fifo_last[wr_ptr] <= pend_last;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------

    // Drive the ports; idle values are zero.
    always_comb begin
        rd_en      = rd_en_c;
        rd_bank    = next_bank;
        rd_addr    = '0;
        if (rd_en_c) begin
            rd_addr = (BITREV != 0) ? bit_reverse(k_cnt) : k_cnt;
        end
        out_data   = head_data;
        out_index  = head_k;
        out_last   = head_last;
        free_pulse = free_c;
        free_bank  = free_c ? next_bank : 1'b0;
        busy       = (state != S_IDLE);
        ovf        = ovf_r;
    end

endmodule
